phy_tx_lane_arbiter: RTL
========================

// Module: phy_tx_lane_arbiter
// PURPOSE
//  Shares the 9-bit parallel input of phy_tx between four byte requesters.
//  Each requester pushes bytes into a private FIFO.
//  A round-robin scheduler pops one byte per clk4f cycle and presents it as
//  {valid, data} on paralelo_out, which feeds phy_tx paralelo lanes.
//  When no data is pending it emits the idle/COM word, so the serializer
//  always sees a defined symbol.
// PARAMETERS
//  DATA_W      8   payload width; paralelo_out is DATA_W+1 bits, MSB = valid
//  FIFO_DEPTH  4   entries per requester FIFO; power of 2, >= 2
//  AFULL_TH    3   occupancy at or above which almost_full[i] is asserted
//  IDLE_SYM    8'hBC  payload driven while idle (K28.5 / COM)
// PORTS
//  clk4f          in   1         single clock; all logic on rising edge
//  reset          in   1         synchronous, active-high reset
//  push           in   4         push[i]: write data_in_i into FIFO i this edge
//  data_in0..3    in   DATA_W    payload for requester 0..3
//  almost_full    out  4         count_i >= AFULL_TH (back-pressure hint)
//  full           out  4         count_i == FIFO_DEPTH
//  overflow_err   out  4         sticky: push dropped on full FIFO i
//  grant          out  2         index of requester whose byte is on paralelo_out
//  paralelo_out   out  DATA_W+1  {valid, payload} to phy_tx
// BEHAVIOUR
//  Reset (sync, checked on each edge, overrides everything):
//  - FIFOs empty, count=0; paralelo_out={1'b0,IDLE_SYM}; grant=0.
//  - overflow_err=0; last-served pointer=3, so requester 0 has first priority.
//  - Asserting reset mid-stream discards all buffered bytes.
//  Eligibility:
//  - FIFO i is eligible at edge k iff count_i > 0 as registered before edge k.
//  - There is no bypass: a byte pushed at edge k is popped at edge k+1 at the
//    earliest. Minimum latency is push edge -> paralelo_out valid after the next edge.
//  Round-robin:
//  - At each edge, search from (last+1) mod 4 upward for the first eligible FIFO.
//  - If one is found: pop it; register paralelo_out <= {1'b1, head}; grant <= i;
//    last <= i.
//  - If none is found: paralelo_out <= {1'b0,IDLE_SYM}; grant and last hold.
//  - A requester with continuous data is served at least once every 4 cycles.
//  - A single active requester is served every cycle.
//  Per-FIFO update at each edge:
//  - push&!pop&!full -> write at wr_ptr, count+1.
//  - pop&!push -> count-1.
//  - push&pop -> write and read both happen; count is unchanged. This is also
//    accepted when full.
//  - push&full&!pop -> byte dropped, overflow_err[i] <= 1 (held until reset).
//  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
//  - count is log2(FIFO_DEPTH)+1 bits.
//  Output flags:
//  - full and almost_full are combinational from registered count.
//  - paralelo_out and grant are registered; no combinational input->output path.
//  - Payload is passed unmodified; the block never inspects data values.
//  - A pushed byte equal to IDLE_SYM is still sent with valid=1.
// TESTING
//  T1 reset: hold reset 2 edges with push=4'hF
//     -> paralelo_out=9'h0BC, grant=0, full=0, overflow_err=0; no bytes stored.
//  T2 single: push0 8'hA5 at edge k
//     -> paralelo_out=9'h1A5, grant=0 after edge k+1; 9'h0BC after edge k+2.
//  T3 fairness: preload FIFOs 0..3 with 8'h10,8'h20,8'h30,8'h40 (2 each)
//     -> output order 10,20,30,40,10,20,30,40, then idle.
//  T4 overflow: push FIFO2 five times, no pops possible (hold via reset-free
//     preload while others monopolize? no: FIFO2 only)
//     -> verify full[2] at count 4 when pops lag.
//     -> A 5th push on a full FIFO without a same-edge pop sets overflow_err[2];
//        data order is kept.
//  T5 push+pop on full FIFO1: same edge -> count stays 4, overflow_err[1]=0,
//     and the new byte emerges 4 pops later.
//  T6 mid-stream reset: reset with 3 bytes queued
//     -> next edge paralelo_out=9'h0BC, all counts 0, requester 0 first after release.

Source files
------------

// File: rtl/phy_tx_lane_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : phy_tx_lane_arbiter
//  Function : Four requester FIFOs drained round-robin, one byte per clk4f,
//             onto the {valid, data} parallel word that feeds phy_tx.
//  Revision : 1.0 - initial release
// ============================================================================
module phy_tx_lane_arbiter #(
    parameter int                DATA_W     = 8,
    parameter int                FIFO_DEPTH = 4,
    parameter int                AFULL_TH   = 3,
    parameter logic [DATA_W-1:0] IDLE_SYM   = 8'hBC
) (
    input  logic              clk4f,
    input  logic              reset,
    input  logic [3:0]        push,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    output logic [3:0]        almost_full,
    output logic [3:0]        full,
    output logic [3:0]        overflow_err,
    output logic [1:0]        grant,
    output logic [DATA_W:0]   paralelo_out
);

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    logic [DATA_W-1:0] w_din   [NUM_REQ];
    logic [DATA_W-1:0] w_head  [NUM_REQ];
    logic [CNT_W-1:0]  w_count [NUM_REQ];

    logic [SEL_W-1:0]  last_q, last_d;
    logic [SEL_W-1:0]  grant_q, grant_d;
    logic [DATA_W:0]   paralelo_q, paralelo_d;

    logic              w_found;
    logic [SEL_W-1:0]  w_sel;
    logic [SEL_W-1:0]  w_cand;

    assign w_din[0] = data_in0;
    assign w_din[1] = data_in1;
    assign w_din[2] = data_in2;
    assign w_din[3] = data_in3;

    // ------------------------------------------------------------------
    // Per-requester FIFO
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
            logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
            logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
            logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
            logic [CNT_W-1:0]  count_q, count_d;
            logic              ovf_q, ovf_d;
            logic              w_pop;
            logic              w_full;
            logic              w_wr;

            assign w_full = (count_q == CNT_W'(FIFO_DEPTH));
            assign w_pop  = w_found && (w_sel == SEL_W'(i));
            // A same-edge pop frees the slot, so a push on a full FIFO is kept.
            assign w_wr   = push[i] && (w_pop || !w_full);

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                ovf_d    = ovf_q;
                if (w_wr) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (w_pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                if (w_wr && !w_pop) begin
                    count_d = count_q + 1'b1;
                end else if (w_pop && !w_wr) begin
                    count_d = count_q - 1'b1;
                end
                if (push[i] && !w_wr) begin
                    ovf_d = 1'b1;
                end
            end

            always_ff @(posedge clk4f) begin
                if (reset) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                    ovf_q    <= 1'b0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                    ovf_q    <= ovf_d;
                end
            end

            always_ff @(posedge clk4f) begin
                if (!reset && w_wr) begin
                    mem_q[wr_ptr_q] <= w_din[i];
                end
            end

            assign w_head[i]       = mem_q[rd_ptr_q];
            assign w_count[i]      = count_q;
            assign full[i]         = w_full;
            assign almost_full[i]  = (count_q >= CNT_W'(AFULL_TH));
            assign overflow_err[i] = ovf_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin search starting just after the last served requester
    // ------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_sel   = last_q;
        w_cand  = last_q;
        for (int j = 1; j <= NUM_REQ; j++) begin
            w_cand = last_q + SEL_W'(j);
            if (!w_found && (w_count[w_cand] != '0)) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_comb begin
        last_d     = last_q;
        grant_d    = grant_q;
        paralelo_d = {1'b0, IDLE_SYM};
        if (w_found) begin
            last_d     = w_sel;
            grant_d    = w_sel;
            paralelo_d = {1'b1, w_head[w_sel]};
        end
    end

    // Requester 0 gets first priority out of reset.
    always_ff @(posedge clk4f) begin
        if (reset) begin
            last_q     <= SEL_W'(NUM_REQ - 1);
            grant_q    <= '0;
            paralelo_q <= {1'b0, IDLE_SYM};
        end else begin
            last_q     <= last_d;
            grant_q    <= grant_d;
            paralelo_q <= paralelo_d;
        end
    end

    assign grant        = grant_q;
    assign paralelo_out = paralelo_q;

endmodule
`default_nettype wire
